// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, field positions, exception codes
// and the default exception handler entry point.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IM_HI     = 15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

endpackage

// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId, plus the
// request logic that redirects the pipeline to the handler.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h2024_0706,
  parameter logic [31:0] HANDLER_ADDR = cp0_pkg::HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  A1,
  input  logic [31:0] CP0_in,
  output logic [31:0] CP0_out,
  input  logic [31:0] VPC,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXL_clr,
  output logic        req,
  output logic [31:0] EPC_out,
  output logic [31:0] handler_pc
);

  // SR.EXL is the mode register itself
  mode_e       mode_q, mode_d;
  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] vpc_aligned;
  logic        unused_vpc;

  assign unused_vpc  = ^VPC[1:0];
  assign vpc_aligned = {VPC[31:2], 2'b00};
  assign int_req     = (|(HWInt & sr_im_q)) & sr_ie_q & (mode_q == MODE_NORMAL);
  assign exc_req     = (ExcCode_in != EXC_INT) & (mode_q == MODE_NORMAL);
  assign req         = int_req | exc_req;
  assign EPC_out     = epc_q;
  assign handler_pc  = HANDLER_ADDR;

  always_comb begin
    mode_d      = mode_q;
    sr_im_d     = sr_im_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      mode_d      = MODE_HANDLER;
      cause_bd_d  = BD_in;
      cause_exc_d = int_req ? EXC_INT : ExcCode_in;
      epc_d       = BD_in ? (vpc_aligned - 32'd4) : vpc_aligned;
    end else begin
      if (en && (A1 == REG_SR)) begin
        sr_im_d = CP0_in[SR_IM_HI:SR_IM_LO];
        sr_ie_d = CP0_in[SR_IE];
        mode_d  = mode_e'(CP0_in[SR_EXL]);
      end
      if (en && (A1 == REG_EPC)) begin
        epc_d = {CP0_in[31:2], 2'b00};
      end
      // eret wins over an mtc0 that writes EXL in the same cycle
      if (EXL_clr) begin
        mode_d = MODE_NORMAL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_NORMAL;
      sr_im_q     <= '0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      sr_im_q     <= sr_im_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    CP0_out = '0;
    case (A1)
      REG_SR: begin
        CP0_out[SR_IM_HI:SR_IM_LO] = sr_im_q;
        CP0_out[SR_EXL]            = (mode_q == MODE_HANDLER);
        CP0_out[SR_IE]             = sr_ie_q;
      end
      REG_CAUSE: begin
        CP0_out[CAUSE_BD]                  = cause_bd_q;
        CP0_out[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip_q;
        CP0_out[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc_q;
      end
      REG_EPC:  CP0_out = epc_q;
      REG_PRID: CP0_out = PRID;
      default:  CP0_out = '0;
    endcase
  end

endmodule
